instr_fetch: RTL and testbench

Fetch stage directly upstream of the single-cycle control unit and datapath. Owns the PC, issues requests to instruction memory over a req/ack handshake, and holds the fetched instruction in a register. Presents opcode/funct3/funct7/rd/rs1/rs2 fields to the decode stage under a valid/ready handshake. Accepts redirects (taken branch/jump) at any time and discards stale fetches.

---
 rtl/riscv_pkg.sv | 25 ++
 rtl/instr_fields.sv | 25 ++
 rtl/instr_fetch.sv | 132 +++++++++++++
 tb/tb_instr_fetch.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared fetch-stage definitions: state encoding, NOP word, instruction field positions.
`default_nettype none

package riscv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2,
    DROP = 2'd3
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  localparam int OPCODE_LSB = 0;
  localparam int RD_LSB     = 7;
  localparam int FUNCT3_LSB = 12;
  localparam int RS1_LSB    = 15;
  localparam int RS2_LSB    = 20;
  localparam int FUNCT7_LSB = 25;

endpackage

`default_nettype wire

// File: rtl/instr_fields.sv
// Splits a 32-bit RISC-V instruction word into its fixed decode fields.
`default_nettype none

module instr_fields
  import riscv_pkg::*;
(
  input  logic [31:0] instr,
  output logic [6:0]  opcode,
  output logic [2:0]  funct3,
  output logic [6:0]  funct7,
  output logic [4:0]  rd,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2
);

  assign opcode = instr[OPCODE_LSB +: 7];
  assign rd     = instr[RD_LSB     +: 5];
  assign funct3 = instr[FUNCT3_LSB +: 3];
  assign rs1    = instr[RS1_LSB    +: 5];
  assign rs2    = instr[RS2_LSB    +: 5];
  assign funct7 = instr[FUNCT7_LSB +: 7];

endmodule

`default_nettype wire

// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC, fetches over req/ack, holds one instruction for decode.
// Optional FETCH_STALL_CNT_EN adds a saturating memory-wait cycle counter (stall_cnt).
`default_nettype none

module instr_fetch
  import riscv_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEFAULT_RESET_PC)
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [31:0]     imem_rdata,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [31:0]     instr,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4,
  output logic [6:0]      opcode,
  output logic [2:0]      funct3,
  output logic [6:0]      funct7,
  output logic [4:0]      rd,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc
`ifdef FETCH_STALL_CNT_EN
  ,
  output logic [31:0]     stall_cnt
`endif
);

  fetch_state_t    state, state_n;
  logic [XLEN-1:0] req_addr, req_addr_n;
  logic [XLEN-1:0] pc_n;
  logic [31:0]     instr_n;
  logic [XLEN-1:0] target;

  assign target   = {redirect_pc[XLEN-1:2], 2'b00};
  assign pc_plus4 = pc + XLEN'(4);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      pc       <= RESET_PC;
      req_addr <= RESET_PC;
      instr    <= NOP_INSTR;
    end else begin
      state    <= state_n;
      pc       <= pc_n;
      req_addr <= req_addr_n;
      instr    <= instr_n;
    end
  end

  always_comb begin
    state_n    = state;
    pc_n       = pc;
    req_addr_n = req_addr;
    instr_n    = instr;
    case (state)
      IDLE: begin
        state_n    = REQ;
        req_addr_n = pc;
        if (redirect) begin
          pc_n       = target;
          req_addr_n = target;
        end
      end
      REQ: begin
        if (redirect) begin
          pc_n = target;
          // Without an ack the old request is still owed by memory and must be drained.
          if (imem_ack) req_addr_n = target;
          else          state_n    = DROP;
        end else if (imem_ack) begin
          instr_n = imem_rdata;
          state_n = HOLD;
        end
      end
      HOLD: begin
        if (redirect) begin
          pc_n       = target;
          req_addr_n = target;
          state_n    = REQ;
        end else if (instr_ready) begin
          pc_n       = pc_plus4;
          req_addr_n = pc_plus4;
          state_n    = REQ;
        end
      end
      DROP: begin
        if (redirect) pc_n = target;
        if (imem_ack) begin
          req_addr_n = redirect ? target : pc;
          state_n    = REQ;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign imem_req    = (state == REQ) || (state == DROP);
  assign instr_valid = (state == HOLD);
  assign imem_addr   = req_addr;

`ifdef FETCH_STALL_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= 32'd0;
    end else if (imem_req && !imem_ack && (stall_cnt != 32'hFFFF_FFFF)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

  instr_fields u_fields (
    .instr  (instr),
    .opcode (opcode),
    .funct3 (funct3),
    .funct7 (funct7),
    .rd     (rd),
    .rs1    (rs1),
    .rs2    (rs2)
  );

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch.sv
// Randomized self-checking bench for instr_fetch against a transaction-level fetch model.
`default_nettype none

module tb_instr_fetch;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic        redirect;
  logic [31:0] redirect_pc;
`ifdef FETCH_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif

  always #5 clk = ~clk;

  instr_fetch #(.XLEN(32), .RESET_PC(RST_PC)) dut (
    .clk         (clk),
    .reset       (reset),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .pc          (pc),
    .pc_plus4    (pc_plus4),
    .opcode      (opcode),
    .funct3      (funct3),
    .funct7      (funct7),
    .rd          (rd),
    .rs1         (rs1),
    .rs2         (rs2),
    .redirect    (redirect),
    .redirect_pc (redirect_pc)
`ifdef FETCH_STALL_CNT_EN
    ,
    .stall_cnt   (stall_cnt)
`endif
  );

  function automatic logic [31:0] mem(input logic [31:0] a);
    if (a == 32'h0) return 32'h0050_0093;
    return (a * 32'h9E37_79B1) ^ {a[15:0], a[31:16]};
  endfunction

  assign imem_rdata = mem(imem_addr);

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Model: what the fetch unit owes memory and decode, not how it is encoded.
  bit          m_fresh;
  bit          m_busy;
  bit          m_stale;
  bit          m_have;
  logic [31:0] m_addr;
  logic [31:0] m_pc;
  logic [31:0] m_instr;
  logic [31:0] m_stalls;

  task automatic model_reset();
    m_fresh  = 1;
    m_busy   = 0;
    m_stale  = 0;
    m_have   = 0;
    m_addr   = RST_PC;
    m_pc     = RST_PC;
    m_instr  = NOP;
    m_stalls = 0;
  endtask

  task automatic model_step(input bit ack, input bit ready, input bit redir, input logic [31:0] rpc);
    logic [31:0] tgt;
    tgt = {rpc[31:2], 2'b00};
    if (m_busy && !ack && m_stalls != 32'hFFFF_FFFF) m_stalls++;
    if (m_fresh) begin
      m_fresh = 0;
      if (redir) m_pc = tgt;
      m_busy = 1;
      m_addr = m_pc;
    end else if (m_have) begin
      if (redir || ready) begin
        m_pc   = redir ? tgt : m_pc + 32'd4;
        m_have = 0;
        m_busy = 1;
        m_addr = m_pc;
      end
    end else if (m_busy && !m_stale) begin
      if (redir) begin
        m_pc = tgt;
        if (ack) m_addr = tgt;
        else     m_stale = 1;
      end else if (ack) begin
        m_instr = mem(m_addr);
        m_have  = 1;
        m_busy  = 0;
      end
    end else if (m_busy) begin
      if (redir) m_pc = tgt;
      if (ack) begin
        m_stale = 0;
        m_addr  = m_pc;
      end
    end
  endtask

  task automatic compare_all();
    check("imem_req", 32'(imem_req), 32'(m_busy));
    if (m_busy) check("imem_addr", imem_addr, m_addr);
    check("instr_valid", 32'(instr_valid), 32'(m_have));
    check("instr", instr, m_instr);
    check("pc", pc, m_pc);
    check("pc_plus4", pc_plus4, m_pc + 32'd4);
    check("opcode", 32'(opcode), 32'(m_instr[6:0]));
    check("rd", 32'(rd), 32'(m_instr[11:7]));
    check("funct3", 32'(funct3), 32'(m_instr[14:12]));
    check("rs1", 32'(rs1), 32'(m_instr[19:15]));
    check("rs2", 32'(rs2), 32'(m_instr[24:20]));
    check("funct7", 32'(funct7), 32'(m_instr[31:25]));
`ifdef FETCH_STALL_CNT_EN
    check("stall_cnt", stall_cnt, m_stalls);
`endif
  endtask

  task automatic step(input bit ack, input bit ready, input bit redir, input logic [31:0] rpc);
    imem_ack    = ack;
    instr_ready = ready;
    redirect    = redir;
    redirect_pc = rpc;
    model_step(ack, ready, redir, rpc);
    @(negedge clk);
    compare_all();
  endtask

  // Keep acking until the model holds an instruction; bounded.
  task automatic fetch_one(input bit ready);
    for (int i = 0; i < 8 && !m_have; i++) step(1, ready, 0, 32'h0);
    check("fetch_bound", 32'(m_have), 32'd1);
  endtask

  initial begin
    reset = 1; imem_ack = 0; instr_ready = 0; redirect = 0; redirect_pc = 0;
    model_reset();
    #12;
    compare_all();
    @(negedge clk);
    reset = 0;
    compare_all();

    // First fetch: ack one cycle after req is raised.
    step(0, 0, 0, 32'h0);
    check("first_addr", imem_addr, 32'h0);
    step(1, 0, 0, 32'h0);
    check("first_valid", 32'(instr_valid), 32'd1);
    check("first_opcode", 32'(opcode), 32'h13);
    check("first_rd", 32'(rd), 32'd1);
    check("first_pc", pc, 32'h0);

    // Sequential streaming with zero-wait memory.
    for (int i = 0; i < 8; i++) step(1, 1, 0, 32'h0);
    check("stream_pc", pc, 32'h10);

    // Decode stall for 5 cycles.
    for (int i = 0; i < 5; i++) step(1, 0, 0, 32'h0);
    check("stall_req_low", 32'(imem_req), 32'd0);

    // Redirect while request is pending, ack delayed.
    step(0, 1, 0, 32'h0);
    step(0, 0, 1, 32'h0000_0102);
    step(0, 0, 0, 32'h0);
    step(0, 0, 0, 32'h0);
    check("drop_old_addr", imem_addr, 32'h14);
    step(1, 0, 0, 32'h0);
    check("drop_new_addr", imem_addr, 32'h100);
    check("drop_no_valid", 32'(instr_valid), 32'd0);
    fetch_one(0);
    check("drop_new_pc", pc, 32'h100);

    // Redirect and ready together in HOLD: redirect wins.
    step(0, 1, 1, 32'h0000_0008);
    fetch_one(0);
    step(0, 1, 1, 32'h0000_0040);
    check("redir_wins", imem_addr, 32'h40);

    // pc+4 wrap.
    fetch_one(0);
    step(0, 0, 1, 32'hFFFF_FFFE);
    fetch_one(0);
    check("wrap_pc4", pc_plus4, 32'h0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] r;
      r = $urandom;
      if ($urandom_range(0, 7) == 0) r = 32'hFFFF_FFF0 | (r & 32'hF);
      step($urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1,
           $urandom_range(0, 9) == 0, r);
    end

    // Reset asserted while draining a stale request.
    fetch_one(0);
    step(0, 1, 0, 32'h0);
    step(0, 0, 1, 32'h0000_0200);
    check("in_drop_req", 32'(imem_req), 32'd1);
    #2 reset = 1;
    model_reset();
    #1;
    compare_all();
    @(negedge clk);
    reset = 0;
    compare_all();

`ifdef FETCH_STALL_CNT_EN
    check("stall_after_reset", stall_cnt, 32'd0);
    step(0, 0, 0, 32'h0);
    step(0, 0, 0, 32'h0);
    step(0, 0, 0, 32'h0);
    step(0, 0, 0, 32'h0);
    step(1, 0, 0, 32'h0);
    check("stall_three", stall_cnt, 32'd3);
`else
    step(0, 0, 0, 32'h0);
    check("post_reset_addr", imem_addr, RST_PC);
`endif
    fetch_one(0);
    check("post_reset_pc", pc, RST_PC);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
